// File: rtl/eforth_fetch_if.sv
// rtl/eforth_fetch_if.sv - program-memory read bus and instruction output stream of the fetch stage
interface eforth_fetch_if #(
  parameter int ASZ = 17,
  parameter int DSZ = 32
);
  logic           mem_re;
  logic [ASZ-1:0] mem_a;
  logic [7:0]     mem_d;
  logic           op_vld;
  logic           op_rdy;
  logic [7:0]     op;
  logic [DSZ-1:0] opnd;
  logic [ASZ-1:0] op_pc;

  modport master (
    output mem_re, mem_a, op_vld, op, opnd, op_pc,
    input  mem_d, op_rdy
  );

  modport slave (
    input  mem_re, mem_a, op_vld, op, opnd, op_pc,
    output mem_d, op_rdy
  );
endinterface

// File: rtl/eforth_fetch.sv
// rtl/eforth_fetch.sv - eForth bytecode fetch and predecode stage
module eforth_fetch #(
  parameter int         ASZ       = 17,
  parameter int         DSZ       = 32,
  parameter logic [7:0] OP_DOLIT  = 8'h02,
  parameter logic [7:0] OP_BRAN   = 8'h03,
  parameter logic [7:0] OP_0BRAN  = 8'h04,
  parameter logic [7:0] OP_DONEXT = 8'h05,
  parameter logic [7:0] OP_BYE    = 8'h7E
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [ASZ-1:0] pfa,
  input  logic           jmp,
  input  logic [ASZ-1:0] jaddr,
  output logic           busy,
  eforth_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, OPC, OPND, HALT} state_t;

  localparam logic [DSZ-1:0] BR_MASK = DSZ'({ASZ{1'b1}});
  localparam logic [ASZ-1:0] ONE     = ASZ'(1);

  state_t         state, state_nx;
  logic [ASZ-1:0] pc;        // next read address
  logic [ASZ-1:0] paddr;     // address of the next byte to be parsed
  logic           infl;      // a read was issued last cycle, mem_d is live
  logic           skid_vld;
  logic [7:0]     skid;
  logic [2:0]     cnt;       // operand bytes still to come
  logic [1:0]     bidx;      // operand byte lane being filled
  logic           cur_br;
  logic [7:0]     cur_op;
  logic [ASZ-1:0] cur_pc;
  logic [DSZ-1:0] acc;
  logic           out_vld;
  logic [7:0]     out_op;
  logic [DSZ-1:0] out_opnd;
  logic [ASZ-1:0] out_pc;

  logic           active, blocked, byte_vld, is_lit, is_br, completes;
  logic           take, hold, load, halt_now, issue;
  logic [7:0]     byte_d;
  logic [DSZ-1:0] asm_val;

  // The skid byte is always older than anything on mem_d, so it parses first.
  assign active    = (state == OPC) || (state == OPND);
  assign blocked   = out_vld && !bus.op_rdy;
  assign byte_vld  = skid_vld || infl;
  assign byte_d    = skid_vld ? skid : bus.mem_d;
  assign is_lit    = (byte_d == OP_DOLIT);
  assign is_br     = (byte_d == OP_BRAN) || (byte_d == OP_0BRAN) || (byte_d == OP_DONEXT);
  assign completes = (state == OPC) ? !(is_lit || is_br) : (cnt == 3'd1);
  // Non-completing bytes may be parsed while the output is stalled; completing ones wait.
  assign take      = active && byte_vld && !jmp && !(blocked && completes);
  assign hold      = active && byte_vld && !jmp && !take;
  assign load      = take && completes;
  assign halt_now  = take && (state == OPC) && (byte_d == OP_BYE);
  assign issue     = active && !jmp && !blocked && !halt_now;
  assign asm_val   = acc | ({{(DSZ-8){1'b0}}, byte_d} << {bidx, 3'b000});

  assign bus.mem_re = issue;
  assign bus.mem_a  = pc;
  assign bus.op_vld = out_vld;
  assign bus.op     = out_op;
  assign bus.opnd   = out_opnd;
  assign bus.op_pc  = out_pc;
  assign busy       = (state != IDLE) || out_vld;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: redirect overrides everything, including IDLE and HALT.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = OPC;
      OPC: begin
        if (halt_now)                  state_nx = HALT;
        else if (take && !completes)   state_nx = OPND;
      end
      OPND: if (take && completes)     state_nx = OPC;
      HALT: if (!blocked)              state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (jmp) state_nx = OPC;
  end

  // Read address, in-flight tracking and skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= '0;
      paddr    <= '0;
      infl     <= 1'b0;
      skid_vld <= 1'b0;
      skid     <= '0;
    end else begin
      infl <= issue;
      if (jmp)                        pc <= jaddr;
      else if (state == IDLE && start) pc <= pfa;
      else if (issue)                 pc <= pc + ONE;

      if (jmp)                        paddr <= jaddr;
      else if (state == IDLE && start) paddr <= pfa;
      else if (take)                  paddr <= paddr + ONE;

      if (jmp || !active)             skid_vld <= 1'b0;
      else if (take && skid_vld)      skid_vld <= 1'b0;
      else if (hold && !skid_vld) begin
        skid_vld <= 1'b1;
        skid     <= bus.mem_d;
      end
    end
  end

  // Opcode latch and operand assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_op <= '0;
      cur_pc <= '0;
      cur_br <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      bidx   <= '0;
    end else if (take) begin
      if (state == OPC) begin
        cur_op <= byte_d;
        cur_pc <= paddr;
        cur_br <= is_br;
        acc    <= '0;
        bidx   <= '0;
        cnt    <= is_lit ? 3'd4 : (is_br ? 3'd3 : 3'd0);
      end else begin
        acc  <= asm_val;
        bidx <= bidx + 2'd1;
        cnt  <= cnt - 3'd1;
      end
    end
  end

  // Output register: loads a finished instruction, clears on accept or redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_op   <= '0;
      out_opnd <= '0;
      out_pc   <= '0;
    end else if (jmp) begin
      out_vld <= 1'b0;
    end else if (load) begin
      out_vld <= 1'b1;
      if (state == OPC) begin
        out_op   <= byte_d;
        out_opnd <= '0;
        out_pc   <= paddr;
      end else begin
        out_op   <= cur_op;
        out_opnd <= cur_br ? (asm_val & BR_MASK) : asm_val;
        out_pc   <= cur_pc;
      end
    end else if (out_vld && bus.op_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eforth_fetch.sv
// tb/tb_eforth_fetch.sv - testbench for eforth_fetch
module tb_eforth_fetch;
  localparam int ASZ = 17;
  localparam int DSZ = 32;
  localparam int MSZ = 1 << ASZ;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           jmp = 1'b0;
  logic [ASZ-1:0] pfa = '0;
  logic [ASZ-1:0] jaddr = '0;
  logic           busy;

  eforth_fetch_if #(.ASZ(ASZ), .DSZ(DSZ)) bus ();

  eforth_fetch #(.ASZ(ASZ), .DSZ(DSZ)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pfa(pfa),
    .jmp(jmp), .jaddr(jaddr), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [MSZ];
  always @(posedge clk) if (bus.mem_re) bus.mem_d <= mem[bus.mem_a];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Read-address monitor: reads must walk the program one byte at a time.
  int             n_reads = 0;
  bit             mon_ra = 0;
  logic [ASZ-1:0] exp_ra = '0;
  always @(negedge clk) begin
    if (bus.mem_re) begin
      n_reads++;
      if (mon_ra) begin
        chk("read_addr", bus.mem_a, exp_ra);
        exp_ra++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put(input logic [ASZ-1:0] a, input logic [7:0] b);
    mem[a] = b;
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    @(negedge clk);
    while ((busy || bus.op_vld) && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk(name, busy, 1'b0);
  endtask

  // From posedge+1: pulse start and count cycles until op_vld (cycle 0 = start cycle).
  task automatic measure(input logic [ASZ-1:0] a, output int lat);
    lat = -1;
    start = 1'b1;
    pfa = a;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.op_vld) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [ASZ-1:0] pfa;
    logic [39:0]    bytes;   // byte i in [8i+7:8i]
    int             nb;
    logic [7:0]     e_op;
    logic [31:0]    e_opnd;
    int             e_lat;
  } vec_t;

  typedef struct {
    logic [7:0]     op;
    logic [31:0]    opnd;
    logic [ASZ-1:0] pc;
  } ins_t;

  // Reference: build a random program from instruction records, then expect
  // exactly those records, in order, at the accept handshakes.
  task automatic rand_run(input int nins, input logic [ASZ-1:0] base, input int rdy_pct);
    ins_t           q[$];
    ins_t           e;
    logic [ASZ-1:0] a;
    logic [31:0]    v;
    logic [7:0]     b;
    logic [7:0]     h_op;
    logic [31:0]    h_opnd;
    logic [ASZ-1:0] h_pc;
    int             k, total, g;
    bit             stalled;
    a = base;
    total = 0;
    for (int i = 0; i < nins; i++) begin
      k = $urandom_range(0, 3);
      v = $urandom;
      if (k <= 1) begin
        do b = 8'($urandom_range(0, 255));
        while (b == 8'h02 || b == 8'h03 || b == 8'h04 || b == 8'h05 || b == 8'h7E);
        put(a, b);
        q.push_back('{b, 32'd0, a});
        a = a + 1; total += 1;
      end else if (k == 2) begin
        put(a, 8'h02);
        for (int j = 0; j < 4; j++) put(a + ASZ'(j + 1), 8'(v >> (8 * j)));
        q.push_back('{8'h02, v, a});
        a = a + 5; total += 5;
      end else begin
        b = 8'(3 + $urandom_range(0, 2));
        put(a, b);
        for (int j = 0; j < 3; j++) put(a + ASZ'(j + 1), 8'(v >> (8 * j)));
        q.push_back('{b, (v % 32'h0100_0000) % (32'd1 << ASZ), a});
        a = a + 4; total += 4;
      end
    end
    put(a, 8'h7E);
    q.push_back('{8'h7E, 32'd0, a});
    total += 1;

    n_reads = 0;
    exp_ra = base;
    mon_ra = 1;
    stalled = 0;
    h_op = '0; h_opnd = '0; h_pc = '0;
    start = 1'b1;
    pfa = base;
    g = 0;
    while (q.size() > 0 && g < 3000) begin
      bus.op_rdy = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      if (bus.op_vld) begin
        if (stalled) begin
          chk("stall_op", bus.op, h_op);
          chk("stall_pc", bus.op_pc, h_pc);
          chk("stall_opnd", bus.opnd, h_opnd);
        end
        if (bus.op_rdy) begin
          e = q.pop_front();
          chk("rnd_op", bus.op, e.op);
          chk("rnd_opnd", bus.opnd, e.opnd);
          chk("rnd_pc", bus.op_pc, e.pc);
        end
      end
      stalled = bus.op_vld && !bus.op_rdy;
      h_op = bus.op; h_pc = bus.op_pc; h_opnd = bus.opnd;
      @(posedge clk); #1;
      start = 1'b0;
      g++;
    end
    chk("rnd_all_accepted", 64'(q.size()), 64'd0);
    bus.op_rdy = 1'b1;
    wait_idle("rnd_idle");
    mon_ra = 0;
    chk("rnd_reads", 64'(n_reads), 64'(total));
  endtask

  vec_t       vt[8];
  int         lat, late, rd;
  logic [7:0] sl[4];

  initial begin
    bus.op_rdy = 1'b0;
    for (int i = 0; i < MSZ; i++) mem[i] = 8'h00;
    #1;
    chk("rst_mem_re", bus.mem_re, 0);
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_op_vld", bus.op_vld, 0);
    chk("rst_op", bus.op, 0);
    chk("rst_opnd", bus.opnd, 0);
    chk("rst_op_pc", bus.op_pc, 0);
    chk("rst_busy", busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // First-instruction table: latency and decode of one instruction per program.
    vt[0] = '{17'h00100, 40'h00_0000_0010, 1, 8'h10, 32'h0, 3};
    vt[1] = '{17'h00200, 40'h12_3456_7802, 5, 8'h02, 32'h1234_5678, 7};
    vt[2] = '{17'h00300, 40'h00_0112_3403, 4, 8'h03, 32'h0001_1234, 6};
    vt[3] = '{17'h00400, 40'h00_FFFF_FF03, 4, 8'h03, 32'h0001_FFFF, 6};
    vt[4] = '{17'h00500, 40'h00_CCBB_AA04, 4, 8'h04, 32'h0000_BBAA, 6};
    vt[5] = '{17'h00600, 40'h00_0000_0105, 4, 8'h05, 32'h0000_0001, 6};
    vt[6] = '{17'h00700, 40'h00_0000_007E, 1, 8'h7E, 32'h0, 3};
    vt[7] = '{17'h1FFFF, 40'h04_0302_0102, 5, 8'h02, 32'h0403_0201, 7};
    bus.op_rdy = 1'b1;
    for (int v = 0; v < 8; v++) begin
      for (int j = 0; j < vt[v].nb; j++) put(vt[v].pfa + ASZ'(j), vt[v].bytes[8*j +: 8]);
      put(vt[v].pfa + ASZ'(vt[v].nb), 8'h7E);
      measure(vt[v].pfa, lat);
      chk("tbl_lat", 64'(lat), 64'(vt[v].e_lat));
      chk("tbl_op", bus.op, vt[v].e_op);
      chk("tbl_opnd", bus.opnd, vt[v].e_opnd);
      chk("tbl_pc", bus.op_pc, vt[v].pfa);
      wait_idle("tbl_idle");
      tick();
    end

    // Straight line: one op per cycle, cycles 3..6, then no reads.
    sl[0] = 8'h10; sl[1] = 8'h11; sl[2] = 8'h12; sl[3] = 8'h7E;
    for (int j = 0; j < 4; j++) put(17'h00100 + ASZ'(j), sl[j]);
    late = 0; rd = 0;
    start = 1'b1; pfa = 17'h00100;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        chk("sl_vld", bus.op_vld, 1'b1);
        chk("sl_op", bus.op, sl[c-3]);
        chk("sl_pc", bus.op_pc, 17'h00100 + ASZ'(c - 3));
      end
      if (bus.mem_re) rd++;
      if (c > 6 && bus.mem_re) late++;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("sl_late_reads", 64'(late), 64'd0);
    chk("sl_reads", 64'(rd), 64'd4);
    chk("sl_busy", busy, 1'b0);

    // Redirect during a DOLIT operand, same cycle as accepting the previous op.
    put(17'h00300, 8'h10); put(17'h00301, 8'h02); put(17'h00302, 8'h78);
    put(17'h00303, 8'h56); put(17'h00304, 8'h34); put(17'h00305, 8'h12);
    put(17'h00306, 8'h7E); put(17'h00200, 8'h11); put(17'h00201, 8'h7E);
    bus.op_rdy = 1'b0;
    for (int c = 0; c < 14; c++) begin
      start = (c == 0);
      pfa = 17'h00300;
      if (c == 5) begin bus.op_rdy = 1'b1; jmp = 1'b1; jaddr = 17'h00200; end
      else jmp = 1'b0;
      @(negedge clk);
      if (c == 3 || c == 5) begin
        chk("jr_vld_hold", bus.op_vld, 1'b1);
        chk("jr_op_hold", bus.op, 8'h10);
      end
      if (c == 6) begin
        chk("jr_mem_re", bus.mem_re, 1'b1);
        chk("jr_mem_a", bus.mem_a, 17'h00200);
      end
      if (c == 6 || c == 7) chk("jr_vld_clear", bus.op_vld, 1'b0);
      if (c == 8) begin
        chk("jr_vld", bus.op_vld, 1'b1);
        chk("jr_op", bus.op, 8'h11);
        chk("jr_pc", bus.op_pc, 17'h00200);
      end
      if (c == 9) begin
        chk("jr_next_op", bus.op, 8'h7E);
        chk("jr_next_pc", bus.op_pc, 17'h00201);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("jr_busy", busy, 1'b0);

    // Address wrap.
    put(17'h1FFFF, 8'h10); put(17'h00000, 8'h11); put(17'h00001, 8'h7E);
    start = 1'b1; pfa = 17'h1FFFF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 3) chk("wrap_pc0", bus.op_pc, 17'h1FFFF);
      if (c == 4) chk("wrap_pc1", bus.op_pc, 17'h00000);
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_idle("wrap_idle");
    tick();

    // Asynchronous reset mid-operand with an instruction held in the output.
    put(17'h00400, 8'h10); put(17'h00401, 8'h02); put(17'h00402, 8'h11);
    put(17'h00403, 8'h22); put(17'h00404, 8'h33); put(17'h00405, 8'h44);
    put(17'h00406, 8'h7E);
    bus.op_rdy = 1'b0;
    start = 1'b1; pfa = 17'h00400;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 4) chk("ar_pre_vld", bus.op_vld, 1'b1);
      if (c < 4) begin @(posedge clk); #1; start = 1'b0; end
    end
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld", bus.op_vld, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_mem_re", bus.mem_re, 1'b0);
    chk("ar_op_pc", bus.op_pc, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    bus.op_rdy = 1'b1;
    measure(17'h00400, lat);
    chk("ar_restart_lat", 64'(lat), 64'd3);
    chk("ar_restart_op", bus.op, 8'h10);
    wait_idle("ar_idle");
    tick();

    // Randomized programs under random backpressure.
    rand_run(20, 17'h01000, 70);
    rand_run(20, 17'h1FFF0, 30);
    rand_run(30, 17'h05000, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/eforth_fetch.md
# eforth_fetch

Bytecode fetch and predecode stage that sits directly upstream of the eForth inner interpreter. It reads the 8-bit opcode stream from program memory, starting at a word's pfa. It gathers the inline operand bytes of literal and branch opcodes, then presents one complete instruction per valid/ready handshake. Redirects (branch taken, call, exit) from the execute stage flush the stream and restart fetch at the new address.

## Interface
- ASZ, 17: address width (128K).
- DSZ, 32: operand/literal width.
- OP_DOLIT, 8'h02: opcode followed by a 4-byte literal.
- OP_BRAN, 8'h03; OP_0BRAN, 8'h04; OP_DONEXT, 8'h05: opcodes followed by a 3-byte address.
- OP_BYE, 8'h7E: terminating opcode; fetch halts after emitting it.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: begin fetching at pfa.
- pfa  in  ASZ  start address, sampled when start=1.
- jmp  in  1  redirect request from execute stage.
- jaddr  in  ASZ  redirect target, sampled when jmp=1.
- mem_re  out  1  memory read strobe.
- mem_a  out  ASZ  read address.
- mem_d  in  8  read data, valid the cycle after mem_re.
- op_vld  out  1  instruction available.
- op_rdy  in  1  execute stage accepts the instruction.
- op  out  8  opcode.
- opnd  out  DSZ  operand, little-endian assembled, zero-extended; 0 for operandless opcodes.
- op_pc  out  ASZ  address of the opcode byte.
- busy  out  1  1 while in any state other than IDLE or while op_vld=1.

## Operation
- Reset values: mem_re=0, mem_a=0, op_vld=0, op=0, opnd=0, op_pc=0, busy=0; state IDLE; pc=0.
- States:
  - IDLE: the block waits. start sets pc=pfa and moves to OPC.
  - OPC: the opcode byte is being read.
  - OPND: operand bytes are being read; a counter cnt holds the remaining bytes.
  - HALT: OP_BYE has been emitted; the block returns to IDLE once op_vld clears.
- Each issued read sends mem_a=pc with mem_re=1, then pc increments. Address arithmetic wraps modulo 2^ASZ.
- Opcode byte returned:
  - Latch op and op_pc.
  - OP_DOLIT: cnt=4, go to OPND.
  - Branch opcodes: cnt=3, go to OPND.
  - Otherwise the instruction is complete.
- Operand byte i (0-based) goes to opnd[8i+7:8i]. Branch operands are truncated to ASZ bits, with the upper bits zero. When cnt reaches 0, the instruction is complete.
- A complete instruction loads the output register: op_vld=1, held stable until op_vld & op_rdy.
- Backpressure: no new read issues while the output register is full and not being accepted. A byte already in flight lands in a 1-entry skid register and is consumed before the next read. Bytes are never dropped and never duplicated.
- OP_BYE: after emitting it, no further reads; state HALT.
- jmp has priority over every other event. In the cycle jmp=1:
  - op_vld clears. An instruction accepted in the same cycle (op_vld & op_rdy) still counts as consumed.
  - The skid entry and any partial operand are discarded.
  - Any in-flight mem_d is ignored.
  - pc=jaddr; state goes to OPC from any state, including IDLE and HALT.
- start while not IDLE is ignored; jmp is the only redirect.

## Timing
- Memory latency: read issued in cycle k, mem_d captured at the end of cycle k+1.
- Start latency: start in cycle 0 → first mem_re in cycle 1 → operandless op_vld in cycle 3.
- Throughput: 1 instruction per cycle for back-to-back operandless opcodes with op_rdy=1. Reads are pipelined; the next read issues in the same cycle the previous data returns.
- OP_DOLIT: op_vld 4 cycles later than an operandless opcode. Branch opcodes: 3 cycles later.
- jmp in cycle j: first mem_re at jaddr in cycle j+1; op_vld (operandless opcode) in cycle j+3.
- rst_n low at any time, including mid-operand: immediately return to reset values. The first start is honored on the first clock edge after deassertion.

## Test plan
- Straight line: memory 0x100 = 10,11,12,7E; start pfa=0x100, op_rdy=1 → ops 10,11,12,7E on consecutive cycles 3–6 with op_pc 0x100–0x103; then busy=0 and no further mem_re.
- Literal: bytes 02,78,56,34,12 → single instruction op=02, opnd=0x12345678; the next opcode is fetched from pfa+5.
- Branch: bytes 03,34,12,01 → opnd=0x11234 (ASZ=17); bytes 03,FF,FF,FF → opnd=0x1FFFF.
- Backpressure: op_rdy=0 for 5 cycles mid-stream → op/op_pc stable while stalled; no byte lost or duplicated; mem_re stays low while both output register and skid are full.
- Redirect: jmp=1, jaddr=0x200 during OPND of a DOLIT, simultaneous with acceptance of the previous op → partial literal discarded; next op_pc=0x200 at j+3.
- Reset/wrap: pfa=0x1FFFF with bytes 10,11 at addresses 0x1FFFF,0x0000 → op_pc 0x1FFFF then 0x0000. Assert rst_n low mid-stream → op_vld=0 asynchronously, state IDLE.
